// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds requester IDs, the last-grant state encoding and default widths/depth.
package dmem_arb_pkg;

  // Requester IDs, used as the select of the memory-side mux.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  // Last-grant state: records which requester owned the most recent beat.
  typedef enum logic {
    LastCore = 1'b0,
    LastDbg  = 1'b1
  } last_gnt_e;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_MEM_DEPTH = 64;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a force input for the debug requester.
// Ports:
//   core_req_i, dbg_req_i : requests
//   last_dbg_i            : 1 when the debug port owned the most recent grant
//   force_dbg_i           : lock in force; debug wins whenever it requests
//   core_gnt_o, dbg_gnt_o : one-hot (or zero) grants
module rr_pick2 (
  input  logic core_req_i,
  input  logic dbg_req_i,
  input  logic last_dbg_i,
  input  logic force_dbg_i,
  output logic core_gnt_o,
  output logic dbg_gnt_o
);

  always_comb begin
    // Debug wins when forced, when uncontested, or when core had the last turn.
    dbg_gnt_o  = dbg_req_i & (force_dbg_i | ~core_req_i | ~last_dbg_i);
    core_gnt_o = core_req_i & ~dbg_gnt_o;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the core load/store path
// and the debug/loader port. Grants are combinational; each granted beat gets
// a registered response one cycle later. Debug may hold the grant for up to
// MAX_BURST consecutive beats using dbg_lock_i.
// Ports:
//   clk_i, reset_ni                        : clock, async active-low reset
//   core_*_i / dbg_*_i                     : requester req/we/addr/wdata
//   dbg_lock_i                             : debug asks to keep the grant
//   core_gnt_o, dbg_gnt_o, core_stall_o    : handshake to requesters
//   core_rvalid_o, dbg_rvalid_o            : response owner (one cycle)
//   rsp_err_o, rsp_rdata_o                 : response status and load data
//   mem_re_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i               : memory side
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              core_rvalid_o,
  output logic              dbg_rvalid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  last_gnt_e       state_q, state_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            core_rvalid_q, dbg_rvalid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              last_dbg;
  logic              lock_force;
  logic              pick_core, pick_dbg;
  logic              core_gnt, dbg_gnt, any_gnt;
  logic              sel_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              do_read, do_write;

  // Last-grant FSM: state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= LastDbg;
    end else begin
      state_q <= state_d;
    end
  end

  // Last-grant FSM: next state.
  always_comb begin
    state_d = state_q;
    if (core_gnt) begin
      state_d = LastCore;
    end else if (dbg_gnt) begin
      state_d = LastDbg;
    end
  end

  // Last-grant FSM: output decode.
  always_comb begin
    last_dbg = (state_q == LastDbg);
  end

  // burst_cnt counts consecutive debug grants, so a non-zero value also means
  // debug was granted in the previous cycle.
  always_comb begin
    lock_force = dbg_req_i & dbg_lock_i & last_dbg &
                 (burst_cnt_q != '0) & (burst_cnt_q < CntMax);
  end

  rr_pick2 u_pick (
    .core_req_i  (core_req_i),
    .dbg_req_i   (dbg_req_i),
    .last_dbg_i  (last_dbg),
    .force_dbg_i (lock_force),
    .core_gnt_o  (pick_core),
    .dbg_gnt_o   (pick_dbg)
  );

  always_comb begin
    // Nothing is granted while reset is held.
    core_gnt  = pick_core & reset_ni;
    dbg_gnt   = pick_dbg & reset_ni;
    any_gnt   = core_gnt | dbg_gnt;
    sel_id    = dbg_gnt ? REQ_DBG : REQ_CORE;
    sel_we    = (sel_id == REQ_DBG) ? dbg_we_i    : core_we_i;
    sel_addr  = (sel_id == REQ_DBG) ? dbg_addr_i  : core_addr_i;
    sel_wdata = (sel_id == REQ_DBG) ? dbg_wdata_i : core_wdata_i;
    in_range  = (sel_addr < ADDR_W'(MEM_DEPTH));
    do_read   = any_gnt & ~sel_we & in_range;
    do_write  = any_gnt & sel_we & in_range;
  end

  always_comb begin
    burst_cnt_d = '0;
    if (dbg_gnt) begin
      burst_cnt_d = (burst_cnt_q == CntMax) ? burst_cnt_q : burst_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      burst_cnt_q   <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      burst_cnt_q   <= burst_cnt_d;
      core_rvalid_q <= core_gnt;
      dbg_rvalid_q  <= dbg_gnt;
      rsp_err_q     <= any_gnt & ~in_range;
      rsp_rdata_q   <= do_read ? mem_rdata_i : '0;
    end
  end

  always_comb begin
    core_gnt_o    = core_gnt;
    dbg_gnt_o     = dbg_gnt;
    core_stall_o  = core_req_i & ~core_gnt & reset_ni;
    mem_re_o      = do_read;
    mem_we_o      = do_write;
    mem_addr_o    = any_gnt ? sel_addr  : '0;
    mem_wdata_o   = any_gnt ? sel_wdata : '0;
    core_rvalid_o = core_rvalid_q;
    dbg_rvalid_o  = dbg_rvalid_q;
    rsp_err_o     = rsp_err_q;
    rsp_rdata_o   = rsp_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table plus hand sequences for the
// lock burst and asynchronous reset. A small memory model backs the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, core_stall, dbg_gnt, core_rvalid, dbg_rvalid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  logic [31:0] mem_q [64];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem_q[mem_addr[5:0]] <= mem_wdata;
  end
  assign mem_rdata = mem_q[mem_addr[5:0]];

  dmem_arbiter dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .core_req_i    (core_req),
    .core_we_i     (core_we),
    .core_addr_i   (core_addr),
    .core_wdata_i  (core_wdata),
    .core_gnt_o    (core_gnt),
    .core_stall_o  (core_stall),
    .dbg_req_i     (dbg_req),
    .dbg_we_i      (dbg_we),
    .dbg_addr_i    (dbg_addr),
    .dbg_wdata_i   (dbg_wdata),
    .dbg_lock_i    (dbg_lock),
    .dbg_gnt_o     (dbg_gnt),
    .core_rvalid_o (core_rvalid),
    .dbg_rvalid_o  (dbg_rvalid),
    .rsp_err_o     (rsp_err),
    .rsp_rdata_o   (rsp_rdata),
    .mem_re_o      (mem_re),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        dl;
    logic        e_cg, e_dg, e_st, e_re, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_cv, e_dv, e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
    dbg_req  = v.dr; dbg_we  = v.dw; dbg_addr  = v.da; dbg_wdata  = v.dd;
    dbg_lock = v.dl;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input int i, input vec_t v);
    drive(v);
    #2;
    chk($sformatf("v%0d core_gnt", i),   {31'b0, core_gnt},   {31'b0, v.e_cg});
    chk($sformatf("v%0d dbg_gnt", i),    {31'b0, dbg_gnt},    {31'b0, v.e_dg});
    chk($sformatf("v%0d core_stall", i), {31'b0, core_stall}, {31'b0, v.e_st});
    chk($sformatf("v%0d mem_re", i),     {31'b0, mem_re},     {31'b0, v.e_re});
    chk($sformatf("v%0d mem_we", i),     {31'b0, mem_we},     {31'b0, v.e_we});
    chk($sformatf("v%0d mem_addr", i),   mem_addr,            v.e_addr);
    chk($sformatf("v%0d mem_wdata", i),  mem_wdata,           v.e_wd);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d core_rvalid", i), {31'b0, core_rvalid}, {31'b0, v.e_cv});
    chk($sformatf("v%0d dbg_rvalid", i),  {31'b0, dbg_rvalid},  {31'b0, v.e_dv});
    chk($sformatf("v%0d rsp_err", i),     {31'b0, rsp_err},     {31'b0, v.e_err});
    chk($sformatf("v%0d rsp_rdata", i),   rsp_rdata,            v.e_rd);
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int k;
    logic exp_dbg;

    //        cr cw ca    cd          dr dw da  dd          dl  cg dg st re we addr  wd          cv dv er rd
    vt[0]  = '{0, 0, 0,   0,          0, 0, 0,  0,          0,  0, 0, 0, 0, 0, 0,    0,          0, 0, 0, 0};
    // First tie after reset: core, dbg, core, dbg.
    vt[1]  = '{1, 1, 10,  32'hC0,     1, 1, 11, 32'hD0,     0,  1, 0, 0, 0, 1, 10,   32'hC0,     1, 0, 0, 0};
    vt[2]  = '{1, 1, 10,  32'hC0,     1, 1, 11, 32'hD0,     0,  0, 1, 1, 0, 1, 11,   32'hD0,     0, 1, 0, 0};
    vt[3]  = '{1, 1, 10,  32'hC0,     1, 1, 11, 32'hD0,     0,  1, 0, 0, 0, 1, 10,   32'hC0,     1, 0, 0, 0};
    vt[4]  = '{1, 1, 10,  32'hC0,     1, 1, 11, 32'hD0,     0,  0, 1, 1, 0, 1, 11,   32'hD0,     0, 1, 0, 0};
    vt[5]  = '{0, 0, 0,   0,          1, 1, 5,  32'hDEADBEEF, 0, 0, 1, 0, 0, 1, 5,   32'hDEADBEEF, 0, 1, 0, 0};
    vt[6]  = '{1, 0, 5,   0,          0, 0, 0,  0,          0,  1, 0, 0, 1, 0, 5,    0,          1, 0, 0, 32'hDEADBEEF};
    vt[7]  = '{1, 1, 3,   32'h1234,   0, 0, 0,  0,          0,  1, 0, 0, 0, 1, 3,    32'h1234,   1, 0, 0, 0};
    vt[8]  = '{1, 0, 3,   0,          0, 0, 0,  0,          0,  1, 0, 0, 1, 0, 3,    0,          1, 0, 0, 32'h1234};
    // Out-of-range beats are consumed with no memory access.
    vt[9]  = '{0, 0, 0,   0,          1, 1, 64, 32'h55,     0,  0, 1, 0, 0, 0, 64,   32'h55,     0, 1, 1, 0};
    vt[10] = '{1, 0, 100, 0,          0, 0, 0,  0,          0,  1, 0, 0, 0, 0, 100,  0,          1, 0, 1, 0};
    vt[11] = '{0, 0, 0,   0,          1, 0, 11, 0,          0,  0, 1, 0, 1, 0, 11,   0,          0, 1, 0, 32'hD0};

    reset_n = 1'b0;
    drive(vt[0]);
    #12;
    chk("rst core_rvalid", {31'b0, core_rvalid}, 32'd0);
    chk("rst dbg_rvalid",  {31'b0, dbg_rvalid},  32'd0);
    chk("rst rsp_err",     {31'b0, rsp_err},     32'd0);
    chk("rst rsp_rdata",   rsp_rdata,            32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) step(i, vt[i]);

    // Lock burst: make core the last grantee so dbg wins the first tie.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'd3; core_wdata = 32'd0;
    dbg_req = 1'b0; dbg_lock = 1'b0;
    #2;
    chk("pre-burst core_gnt", {31'b0, core_gnt}, 32'd1);
    @(negedge clk);

    idx = 0;
    k   = 0;
    while (idx < 12 && k < 20) begin
      dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1;
      dbg_addr = idx; dbg_wdata = 32'hA000_0000 + idx;
      #2;
      exp_dbg = (k != 8);
      chk($sformatf("burst%0d dbg_gnt", k),  {31'b0, dbg_gnt},  {31'b0, exp_dbg});
      chk($sformatf("burst%0d core_gnt", k), {31'b0, core_gnt}, {31'b0, ~exp_dbg});
      if (dbg_gnt) begin
        chk($sformatf("burst%0d mem_addr", k), mem_addr, idx);
        idx++;
      end
      k++;
      @(negedge clk);
    end
    chk("burst beats done", idx, 32'd12);
    chk("burst cycles", k, 32'd13);
    dbg_req = 1'b0; dbg_lock = 1'b0; core_req = 1'b0;
    for (int i = 0; i < 12; i++) chk($sformatf("mem[%0d]", i), mem_q[i], 32'hA000_0000 + i);

    // Reset with a locked burst and a response pending.
    @(negedge clk);
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd20; dbg_wdata = 32'h20;
    #2;
    chk("rst-seq beat1 dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'd3;
    dbg_addr = 32'd21; dbg_wdata = 32'h21;
    #2;
    chk("rst-seq beat2 locked dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("rst-seq beat2 core_stall", {31'b0, core_stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst-seq pending dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("in-rst dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("in-rst dbg_gnt",    {31'b0, dbg_gnt},    32'd0);
    chk("in-rst core_gnt",   {31'b0, core_gnt},   32'd0);
    chk("in-rst core_stall", {31'b0, core_stall}, 32'd0);
    chk("in-rst mem_we",     {31'b0, mem_we},     32'd0);
    chk("in-rst mem_re",     {31'b0, mem_re},     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    // Lock still requested, but the burst count was cleared: the tie goes to core.
    chk("post-rst tie core_gnt", {31'b0, core_gnt}, 32'd1);
    chk("post-rst tie dbg_gnt",  {31'b0, dbg_gnt},  32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory between the core's load/store path and the debug/loader port. It sits between the core's MemRead/MemWrite/address/write-data signals and the data memory. It uses round-robin arbitration with an optional bounded lock for loader bursts, and returns a registered one-cycle response per granted beat. It also drives a stall to the core while the core's request waits, and range-checks word addresses.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 32, requester address width (word index)
- MEM_DEPTH, 64, number of memory words; legal addresses 0..MEM_DEPTH-1
- MAX_BURST, 8, max consecutive locked grants to the debug port (≥1)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- core_req  in  1  core transaction valid (load or store)
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  store data
- core_gnt  out  1  core beat accepted this cycle
- core_stall  out  1  core_req & ~core_gnt
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug-port request, same meaning as core_*
- dbg_lock  in  1  request to keep grant for consecutive beats
- dbg_gnt  out  1  debug beat accepted this cycle
- core_rvalid, dbg_rvalid  out  1  response for that requester's beat granted last cycle
- rsp_err  out  1  response error: the address was out of range
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- mem_re, mem_we  out  1  memory read / write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational read data from memory

## Operation
- Valid/ready handshake. A requester holds req, we, addr and wdata stable until its gnt is high. A beat transfers on a cycle with req & gnt.
- At most one gnt is high per cycle. Grants are combinational from req and the registered state.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted most recently wins. The last-grant register updates on every granted beat.
- Lock:
  - Applies when dbg was granted last cycle, dbg_req and dbg_lock are both still high, and burst_cnt < MAX_BURST.
  - Under these conditions dbg is granted regardless of core_req, and burst_cnt increments.
  - burst_cnt clears on any cycle without a dbg grant.
  - When burst_cnt = MAX_BURST, the next contested cycle goes to core.
- Memory side, for the granted beat:
  - mem_addr, mem_wdata and mem_we come from the granted requester's signals.
  - mem_re = ~we.
  - With no grant, mem_re = mem_we = 0, and mem_addr/mem_wdata = 0.
- Range check: a granted beat with addr ≥ MEM_DEPTH is still consumed (gnt = 1), but mem_re and mem_we are forced to 0. Its response has rsp_err = 1 and rsp_rdata = 0.
- Response: registered at the edge that ends the granted cycle.
  - Loads capture mem_rdata.
  - Exactly one of core_rvalid/dbg_rvalid is high for one cycle, identifying the owner.
- FSM (last-grant state): LAST_CORE and LAST_DBG.
  - A core grant moves to LAST_CORE; a dbg grant moves to LAST_DBG.
  - No grant holds the current state.

## Timing
- Grant latency is 0 cycles: an uncontested req is granted in the same cycle.
- Response latency is 1 cycle after the grant. Back-to-back beats give a response every cycle.
- Reset values:
  - Last-grant state = LAST_DBG, so core wins the first tie.
  - burst_cnt = 0.
  - core_rvalid = dbg_rvalid = rsp_err = 0; rsp_rdata = 0.
- While reset_n = 0, all gnt, stall, mem_re and mem_we outputs are forced to 0.
- Reset asserted mid-burst or with a response pending: the response is dropped, the lock is released and the state is reinitialised immediately (asynchronous reset).
- A requester dropping req without a grant is legal. That cycle has no effect on state except clearing burst_cnt if there is no dbg grant.
- burst_cnt saturates at MAX_BURST and never wraps.

## Structure
- Shared package dmem_arb_pkg holds:
  - the requester-ID constants (REQ_CORE = 0, REQ_DBG = 1);
  - the last-grant state encoding;
  - default DATA_W, ADDR_W and MEM_DEPTH.
- Sub-module rr_pick2 is combinational: two reqs, last-grant and lock-force inputs produce one-hot grants. It is instantiated once.
- All registers live in dmem_arbiter: last-grant, burst_cnt, response owner, err and rdata.

## Test plan
- core_req only, load addr 5, with mem[5] = 0xDEADBEEF: core_gnt = 1 in the same cycle and core_stall = 0. Next cycle core_rvalid = 1 and rsp_rdata = 0xDEADBEEF.
- First tie after reset: both req in the same cycle, held for 4 cycles. Grants alternate core, dbg, core, dbg, with core_stall = 1 exactly on the dbg cycles.
- dbg_lock with 12 dbg stores to addr 0..11 while core_req is held high: dbg is granted 8 consecutive beats, then core is granted once, then dbg resumes.
- dbg store to addr 64 (MEM_DEPTH = 64): dbg_gnt = 1 and mem_we = 0. Next cycle dbg_rvalid = 1, rsp_err = 1, rsp_rdata = 0.
- Core store 0x1234 to addr 3, then core load from addr 3 on consecutive cycles: two responses, and the second has rsp_rdata = 0x1234.
- Drop reset_n in the cycle after a dbg grant under lock: dbg_rvalid = 0 and burst_cnt = 0. After release, a tied request is granted to core.
